// File: rtl/enemy_fish_scheduler.sv
// Enemy fish pool controller: staggers and respawns N_FISH enemy slots with LFSR-derived
// parameters, and resolves player collisions round-robin into eat/grow or game over.
module enemy_fish_scheduler #(
    parameter int          N_FISH        = 4,
    parameter int          RESPAWN_TICKS = 120,
    parameter int          STAGGER_TICKS = 30,
    parameter int          MIN_SIZE      = 10,
    parameter int          MAX_SIZE      = 40,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_tick,
    input  logic                          start,
    input  logic [N_FISH-1:0]             hit,
    input  logic signed [11:0]            player_size,
    output logic [N_FISH-1:0]             fish_rst,
    output logic [N_FISH-1:0]             eat,
    output logic signed [11*N_FISH-1:0]   ini_y,
    output logic signed [11*N_FISH-1:0]   ini_x,
    output logic [N_FISH-1:0]             dir_x,
    output logic [N_FISH-1:0]             dir_y,
    output logic signed [12*N_FISH-1:0]   size,
    output logic                          grow,
    output logic [15:0]                   score,
    output logic                          game_over
);
    localparam int IW = $clog2(N_FISH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_OVER} top_t;
    typedef enum logic [1:0] {SL_EMPTY, SL_PEND, SL_SPAWN, SL_ALIVE} slot_t;

    top_t               state;
    slot_t              slot_st [N_FISH];
    logic [15:0]        cnt     [N_FISH];
    logic signed [10:0] ini_y_r [N_FISH];
    logic signed [10:0] ini_x_r [N_FISH];
    logic signed [11:0] size_r  [N_FISH];
    logic [15:0]        lfsr;
    logic [N_FISH-1:0]  hit_q, alive, cand, spawn_gnt;
    logic [IW-1:0]      rr, rr_nxt, hit_idx;
    logic               hit_valid, hit_win;
    logic [10:0]        new_y, new_x;
    logic [11:0]        raw_size, new_size;

    always_comb begin
        spawn_gnt = '0;
        alive     = '0;
        for (int i = N_FISH-1; i >= 0; i--) begin
            alive[i] = (slot_st[i] == SL_ALIVE);
            if (slot_st[i] == SL_PEND) begin
                spawn_gnt    = '0;
                spawn_gnt[i] = 1'b1;
            end
        end
    end

    assign cand = hit_q & alive;

    // Round-robin: scan downward so the candidate closest after rr is the last one kept.
    always_comb begin
        int k;
        k         = 0;
        hit_valid = 1'b0;
        hit_idx   = '0;
        for (int j = N_FISH-1; j >= 0; j--) begin
            k = (int'(rr) + j) % N_FISH;
            if (cand[k]) begin
                hit_valid = 1'b1;
                hit_idx   = IW'(k);
            end
        end
    end

    assign hit_win  = size_r[hit_idx] < player_size;
    assign rr_nxt   = (hit_idx == IW'(N_FISH-1)) ? '0 : hit_idx + IW'(1);

    assign new_y    = {3'b000, lfsr[7:0]};
    assign new_x    = 11'd100 + {2'b00, lfsr[15:8], 1'b0};
    assign raw_size = 12'(MIN_SIZE) + {7'b0, lfsr[12:8]};
    assign new_size = (raw_size > 12'(MAX_SIZE)) ? 12'(MAX_SIZE) : raw_size;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            lfsr      <= LFSR_SEED;
            hit_q     <= '0;
            rr        <= '0;
            grow      <= 1'b0;
            score     <= '0;
            game_over <= 1'b0;
            fish_rst  <= '1;
            eat       <= '0;
            dir_x     <= '0;
            dir_y     <= '0;
            for (int i = 0; i < N_FISH; i++) begin
                slot_st[i] <= SL_EMPTY;
                cnt[i]     <= '0;
                ini_y_r[i] <= '0;
                ini_x_r[i] <= '0;
                size_r[i]  <= 12'(MIN_SIZE);
            end
        end else begin
            lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            grow  <= 1'b0;
            hit_q <= start ? '0 : hit;
            if (start) begin
                state     <= ST_RUN;
                score     <= '0;
                game_over <= 1'b0;
                for (int i = 0; i < N_FISH; i++) begin
                    slot_st[i]  <= SL_EMPTY;
                    cnt[i]      <= 16'(i * STAGGER_TICKS);
                    eat[i]      <= 1'b0;
                    fish_rst[i] <= 1'b1;
                end
            end else if (state == ST_RUN) begin
                for (int i = 0; i < N_FISH; i++) begin
                    case (slot_st[i])
                        SL_EMPTY: begin
                            if (cnt[i] == '0)
                                slot_st[i] <= SL_PEND;
                            else if (frame_tick)
                                cnt[i] <= cnt[i] - 16'd1;
                        end
                        SL_PEND: begin
                            if (spawn_gnt[i]) begin
                                slot_st[i] <= SL_SPAWN;
                                ini_y_r[i] <= new_y;
                                ini_x_r[i] <= new_x;
                                size_r[i]  <= new_size;
                                dir_x[i]   <= lfsr[0];
                                dir_y[i]   <= lfsr[1];
                            end
                        end
                        SL_SPAWN: begin
                            slot_st[i]  <= SL_ALIVE;
                            eat[i]      <= 1'b1;
                            fish_rst[i] <= 1'b0;
                        end
                        default: begin
                            if (hit_valid && hit_win && hit_idx == IW'(i)) begin
                                slot_st[i]  <= SL_EMPTY;
                                cnt[i]      <= 16'(RESPAWN_TICKS);
                                eat[i]      <= 1'b0;
                                fish_rst[i] <= 1'b1;
                            end
                        end
                    endcase
                end
                if (hit_valid) begin
                    rr <= rr_nxt;
                    if (hit_win) begin
                        grow <= 1'b1;
                        if (score != 16'hFFFF)
                            score <= score + 16'd1;
                    end else begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < N_FISH; g++) begin : g_pack
        assign ini_y[11*g +: 11] = ini_y_r[g];
        assign ini_x[11*g +: 11] = ini_x_r[g];
        assign size[12*g +: 12]  = size_r[g];
    end

endmodule

// File: tb/tb_enemy_fish_scheduler.sv
// Bench for enemy_fish_scheduler: behavioural game model checked every cycle, plus literal pins.
module tb_enemy_fish_scheduler;
    localparam int N     = 4;
    localparam int RESP  = 120;
    localparam int STAG  = 30;
    localparam int MINS  = 10;
    localparam int MAXS  = 40;
    // Two steps before 16'hFFFF, so the first grant after reset+start sees L = 16'hFFFF.
    localparam logic [15:0] SEED = 16'h47FF;
    localparam int EMPTY = 0, PEND = 1, SPAWN = 2, ALIVE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_tick = 1'b0;
    logic start = 1'b0;
    logic [N-1:0] hit = '0;
    logic signed [11:0] player_size = 12'sd20;
    logic [N-1:0] fish_rst, eat, dir_x, dir_y;
    logic signed [11*N-1:0] ini_y, ini_x;
    logic signed [12*N-1:0] size;
    logic grow, game_over;
    logic [15:0] score;

    int n_chk = 0;
    int n_fail = 0;
    bit ft_en = 1'b0;
    int ft_cnt = 0;

    enemy_fish_scheduler #(
        .N_FISH(N), .RESPAWN_TICKS(RESP), .STAGGER_TICKS(STAG),
        .MIN_SIZE(MINS), .MAX_SIZE(MAXS), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .hit(hit),
        .player_size(player_size), .fish_rst(fish_rst), .eat(eat), .ini_y(ini_y),
        .ini_x(ini_x), .dir_x(dir_x), .dir_y(dir_y), .size(size), .grow(grow),
        .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_top;
    int m_ph [N];
    int m_cnt [N];
    int m_x [N];
    int m_y [N];
    int m_sz [N];
    bit m_dx [N];
    bit m_dy [N];
    int m_rr, m_score;
    bit m_grow;
    logic [15:0] m_lfsr;
    logic [N-1:0] m_hq;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_reset();
        m_top = 0; m_rr = 0; m_score = 0; m_grow = 0; m_lfsr = SEED; m_hq = '0;
        for (int i = 0; i < N; i++) begin
            m_ph[i] = EMPTY; m_cnt[i] = 0; m_x[i] = 0; m_y[i] = 0;
            m_sz[i] = MINS; m_dx[i] = 0; m_dy[i] = 0;
        end
    endtask

    task automatic model_step(input bit st, input bit ft, input logic [N-1:0] h, input int ps);
        logic [15:0] l;
        logic [N-1:0] hq_seen;
        int hk, sk, k;
        l = m_lfsr;
        m_lfsr = lfsr_next(l);
        m_grow = 0;
        hq_seen = m_hq;
        m_hq = st ? '0 : h;
        if (st) begin
            m_top = 1; m_score = 0;
            for (int i = 0; i < N; i++) begin
                m_ph[i] = EMPTY; m_cnt[i] = i * STAG;
            end
        end else if (m_top == 1) begin
            hk = -1; sk = -1;
            for (int j = 0; j < N; j++) begin
                k = (m_rr + j) % N;
                if (hk < 0 && hq_seen[k] && m_ph[k] == ALIVE) hk = k;
            end
            for (int i = 0; i < N; i++)
                if (sk < 0 && m_ph[i] == PEND) sk = i;
            for (int i = 0; i < N; i++) begin
                case (m_ph[i])
                    EMPTY: if (m_cnt[i] == 0) m_ph[i] = PEND; else if (ft) m_cnt[i]--;
                    PEND: if (i == sk) begin
                        m_ph[i] = SPAWN;
                        m_y[i]  = int'(l[7:0]);
                        m_x[i]  = 100 + 2 * int'(l[15:8]);
                        m_sz[i] = (MINS + int'(l[12:8]) > MAXS) ? MAXS : MINS + int'(l[12:8]);
                        m_dx[i] = l[0];
                        m_dy[i] = l[1];
                    end
                    SPAWN: m_ph[i] = ALIVE;
                    default: if (i == hk && m_sz[i] < ps) begin
                        m_ph[i] = EMPTY; m_cnt[i] = RESP;
                    end
                endcase
            end
            if (hk >= 0) begin
                m_rr = (hk + 1) % N;
                if (m_sz[hk] < ps) begin
                    m_grow = 1;
                    if (m_score < 65535) m_score++;
                end else m_top = 2;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [N-1:0] e_eat, e_rst, e_dx, e_dy;
        logic [11*N-1:0] e_x, e_y;
        logic [12*N-1:0] e_sz;
        for (int i = 0; i < N; i++) begin
            e_eat[i] = (m_ph[i] == ALIVE);
            e_rst[i] = (m_ph[i] != ALIVE);
            e_dx[i] = m_dx[i];
            e_dy[i] = m_dy[i];
            e_x[11*i +: 11] = 11'(m_x[i]);
            e_y[11*i +: 11] = 11'(m_y[i]);
            e_sz[12*i +: 12] = 12'(m_sz[i]);
        end
        chk("eat", {60'h0, eat}, {60'h0, e_eat});
        chk("fish_rst", {60'h0, fish_rst}, {60'h0, e_rst});
        chk("dir_x", {60'h0, dir_x}, {60'h0, e_dx});
        chk("dir_y", {60'h0, dir_y}, {60'h0, e_dy});
        chk("ini_x", {20'h0, ini_x}, {20'h0, e_x});
        chk("ini_y", {20'h0, ini_y}, {20'h0, e_y});
        chk("size", {16'h0, size}, {16'h0, e_sz});
        chk("grow", {63'h0, grow}, {63'h0, m_grow});
        chk("score", {48'h0, score}, 64'(m_score));
        chk("game_over", {63'h0, game_over}, {63'h0, (m_top == 2)});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else model_step(start, frame_tick, hit, int'(player_size));
            @(negedge clk);
            if (!rst) compare();
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            ft_cnt++;
            frame_tick = ft_en && (ft_cnt % 3 == 0);
        end
    end

    task automatic wait_alive(input logic [N-1:0] mask, input int budget, input string name);
        bit done;
        done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk); #1;
            done = 1;
            for (int i = 0; i < N; i++)
                if (mask[i] && m_ph[i] != ALIVE) done = 0;
        end
        chk(name, {63'h0, done}, 64'h1);
    endtask

    task automatic tick(); @(posedge clk); #1; endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_fish_rst"}, {60'h0, fish_rst}, 64'hF);
        chk({tag, "_eat"}, {60'h0, eat}, 64'h0);
        chk({tag, "_ini_x"}, {20'h0, ini_x}, 64'h0);
        chk({tag, "_ini_y"}, {20'h0, ini_y}, 64'h0);
        chk({tag, "_dir"}, {56'h0, dir_x, dir_y}, 64'h0);
        chk({tag, "_size"}, {16'h0, size}, 64'h00A_00A_00A_00A);
        chk({tag, "_score"}, {48'h0, score}, 64'h0);
        chk({tag, "_grow_go"}, {62'h0, grow, game_over}, 64'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 0; start = 1; ft_en = 1;
        tick(); start = 0;                 // after edge 1: RUN
        tick();                            // after edge 2: slot 0 PEND
        tick();                            // after edge 3: SPAWN with L = FFFF
        chk("spawn_fish_rst0", {63'h0, fish_rst[0]}, 64'h1);
        chk("spawn_eat0", {63'h0, eat[0]}, 64'h0);
        chk("ffff_ini_x", {53'h0, ini_x[10:0]}, 64'd610);
        chk("ffff_ini_y", {53'h0, ini_y[10:0]}, 64'd255);
        chk("ffff_size", {52'h0, size[11:0]}, 64'd40);
        chk("ffff_dir", {62'h0, dir_x[0], dir_y[0]}, 64'h3);
        tick();
        chk("alive_eat0", {63'h0, eat[0]}, 64'h1);
        chk("alive_fish_rst0", {63'h0, fish_rst[0]}, 64'h0);

        // Three simultaneous winning hits resolve 0, 1, 3 on consecutive cycles.
        wait_alive(4'b1111, 1500, "wait_all_alive");
        player_size = 12'sd100;
        hit = 4'b1011;
        tick();
        chk("tri_lat_grow", {63'h0, grow}, 64'h0);
        tick();
        chk("tri1", {47'h0, eat[0], grow, score}, {47'h0, 1'b0, 1'b1, 16'd1});
        tick(); hit = '0;
        chk("tri2", {47'h0, eat[1], grow, score}, {47'h0, 1'b0, 1'b1, 16'd2});
        tick();
        chk("tri3", {47'h0, eat[3], grow, score}, {47'h0, 1'b0, 1'b1, 16'd3});
        tick();
        chk("tri_end", {47'h0, eat[2], grow, score}, {47'h0, 1'b1, 1'b0, 16'd3});

        // Respawn, then smallest winning margin on slot 0.
        wait_alive(4'b1111, 1500, "wait_respawn");
        player_size = 12'(m_sz[0] + 1);
        hit = 4'b0001;
        tick(); hit = '0;
        tick();
        chk("win_min", {47'h0, eat[0], grow, score}, {47'h0, 1'b0, 1'b1, 16'd4});

        // Equal size loses: slot 2 ends the game.
        wait_alive(4'b0100, 10, "wait_slot2");
        player_size = 12'(m_sz[2]);
        hit = 4'b0100;
        tick(); hit = '0;
        chk("lose_lat", {63'h0, game_over}, 64'h0);
        tick();
        chk("lose_go", {63'h0, game_over}, 64'h1);
        player_size = 12'sd100;
        hit = 4'b1111;
        repeat (3) tick();
        hit = '0;
        repeat (20) tick();
        chk("over_hold", {47'h0, eat[2], game_over, score}, {47'h0, 1'b1, 1'b1, 16'd4});

        // Restart from OVER.
        start = 1;
        tick(); start = 0;
        chk("restart", {42'h0, eat, fish_rst, game_over, score},
            {42'h0, 4'h0, 4'hF, 1'b0, 16'd0});
        wait_alive(4'b0001, 10, "wait_restart_slot0");
        repeat (5) tick();

        // Asynchronous reset between clock edges.
        @(negedge clk); #2;
        rst = 1;
        #1 chk_reset_outputs("async");
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (5) tick();
        start = 1;
        tick(); start = 0;
        repeat (30) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

endmodule
